pio_latch_arbiter: RTL and testbench

- Shares the single 8-bit parallel-port latch (6529-style: cs high-active, clocked write/port-capture, combinational read returning 8'hff when not selected) between two requesters.
- Requester 1 is the CPU bus, which has absolute priority with zero added latency.
- Requester 2 is an auxiliary master (OSD/keystroke injector) that uses a req/ack handshake. It is granted only in CPU-quiet windows.
- Sits between the CPU address decode and the latch instance.

---
 rtl/pio_latch_arbiter_pkg.sv | 21 ++
 rtl/pio_latch_arbiter_sat_counter.sv | 26 ++
 rtl/pio_latch_arbiter.sv | 154 +++++++++++++++
 tb/tb_pio_latch_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_latch_arbiter_pkg.sv
// Shared types and constants for the parallel-port latch arbiter.
// State encodings, idle data pattern and default timing limits.
package pio_latch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [7:0] PIO_IDLE_DATA = 8'hff;
  localparam logic [7:0] PIO_ZERO_DATA = 8'h00;

  localparam int DEF_QUIET_CYCLES = 2;
  localparam int DEF_MAX_WAIT     = 1023;

  localparam int QUIET_W = 4;
  localparam int WAIT_W  = 10;

endpackage

// File: rtl/pio_latch_arbiter_sat_counter.sv
// Up-counter with synchronous clear that holds at LIMIT.
// Used for the CPU quiet window and the aux wait timer.
module sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pio_latch_arbiter.sv
// Shares one 6529-style port latch between the CPU bus and an aux master.
// CPU always wins with no added latency; aux issues only in quiet windows.
module pio_latch_arbiter
  import pio_latch_arbiter_pkg::*;
#(
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
  parameter int MAX_WAIT     = DEF_MAX_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_cs,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       aux_req,
  input  logic       aux_rw,
  input  logic [7:0] aux_din,
  output logic [7:0] aux_dout,
  output logic       aux_ack,
  output logic       aux_busy,
  output logic       aux_starved,
  output logic       pio_cs,
  output logic       pio_rw,
  output logic [7:0] pio_din,
  input  logic [7:0] pio_dout
);

  localparam logic [QUIET_W-1:0] Q_LIM =
    QUIET_W'(QUIET_CYCLES);
  localparam logic [WAIT_W-1:0] W_LIM =
    WAIT_W'(MAX_WAIT);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [QUIET_W-1:0] quiet_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wait_inc;
  logic               wait_clr;
  logic               aux_go;
  logic               starve_set;

  sat_counter #(
    .W     (QUIET_W),
    .LIMIT (QUIET_CYCLES)
  ) u_quiet (
    .clk   (clk),
    .reset (reset),
    .clr   (cpu_cs),
    .en    (1'b1),
    .cnt   (quiet_cnt)
  );

  sat_counter #(
    .W     (WAIT_W),
    .LIMIT (MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .en    (wait_inc),
    .cnt   (wait_cnt)
  );

  assign wait_clr = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_inc   = 1'b0;
    aux_go     = 1'b0;
    starve_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (aux_req) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!aux_req) begin
          state_nxt = IDLE;
        end else if ((quiet_cnt == Q_LIM) && !cpu_cs) begin
          state_nxt = ISSUE;
        end else begin
          wait_inc   = 1'b1;
          starve_set = (wait_cnt >= (W_LIM - WAIT_W'(1)));
        end
      end
      ISSUE: begin
        // A late CPU select pre-empts the slot; retry after a new window.
        if (cpu_cs) begin
          state_nxt = WAIT;
        end else begin
          aux_go    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    pio_cs  = 1'b0;
    pio_rw  = 1'b1;
    pio_din = PIO_ZERO_DATA;
    if (cpu_cs) begin
      pio_cs  = 1'b1;
      pio_rw  = cpu_rw;
      pio_din = cpu_din;
    end else if (aux_go) begin
      pio_cs  = 1'b1;
      pio_rw  = aux_rw;
      pio_din = aux_din;
    end
  end

  assign cpu_dout = (cpu_cs && cpu_rw) ? pio_dout
                                       : PIO_IDLE_DATA;

  assign aux_ack  = (state == DONE);
  assign aux_busy = (state == WAIT) || (state == ISSUE);

  // Read data is the latch output before the edge closing ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aux_dout <= PIO_IDLE_DATA;
    end else if (aux_go && aux_rw) begin
      aux_dout <= pio_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aux_starved <= 1'b0;
    end else if (state == DONE) begin
      aux_starved <= 1'b0;
    end else if (starve_set) begin
      aux_starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_latch_arbiter.sv
// Self-checking bench for pio_latch_arbiter with a behavioural port latch.
// Vector table for the CPU path, scoreboarded aux transactions.
module tb_pio_latch_arbiter;

  logic       clk;
  logic       reset;
  logic       cpu_cs;
  logic       cpu_rw;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       aux_req;
  logic       aux_rw;
  logic [7:0] aux_din;
  logic [7:0] aux_dout;
  logic       aux_ack;
  logic       aux_busy;
  logic       aux_starved;
  logic       pio_cs;
  logic       pio_rw;
  logic [7:0] pio_din;
  logic [7:0] pio_dout;

  logic [7:0] latch_q;

  int chk_cnt;
  int pass_cnt;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [7:0] din;
    logic       e_cs;
    logic       e_rw;
    logic [7:0] e_din;
    logic [7:0] e_dout;
  } vec_t;

  typedef struct {
    int         lat;
    logic [7:0] dout;
    logic       prw;
    logic [7:0] pdin;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  pio_latch_arbiter #(
    .QUIET_CYCLES (2),
    .MAX_WAIT     (1023)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_cs      (cpu_cs),
    .cpu_rw      (cpu_rw),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .aux_req     (aux_req),
    .aux_rw      (aux_rw),
    .aux_din     (aux_din),
    .aux_dout    (aux_dout),
    .aux_ack     (aux_ack),
    .aux_busy    (aux_busy),
    .aux_starved (aux_starved),
    .pio_cs      (pio_cs),
    .pio_rw      (pio_rw),
    .pio_din     (pio_din),
    .pio_dout    (pio_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 6529-style latch: clocked write, combinational read, ff when deselected
  initial latch_q = 8'h00;
  always @(posedge clk) begin
    if (pio_cs && !pio_rw) latch_q <= pio_din;
  end
  assign pio_dout = (pio_cs && pio_rw) ? latch_q : 8'hff;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_cs = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_read_chk(input string nm, input logic [7:0] exp);
    cpu_cs = 1'b1;
    cpu_rw = 1'b1;
    @(negedge clk);
    chk(nm, cpu_dout, exp);
    step();
    cpu_cs = 1'b0;
  endtask

  task automatic aux_txn(input string      nm,
                         input logic       rw,
                         input logic [7:0] din,
                         input int         cpu_cyc,
                         input logic [7:0] cpu_d,
                         input int         e_lat,
                         input logic [7:0] e_dout,
                         input logic [7:0] e_pdin);
    exp_t       e;
    exp_t       got;
    int         pulses;
    int         lat;
    logic [7:0] pd;
    logic       prw;
    logic [7:0] dout_ack;
    e.lat  = e_lat;
    e.dout = e_dout;
    e.prw  = rw;
    e.pdin = e_pdin;
    sb.push_back(e);
    pulses   = 0;
    lat      = -1;
    pd       = 8'h00;
    prw      = 1'b0;
    dout_ack = 8'h00;
    aux_req  = 1'b1;
    aux_rw   = rw;
    aux_din  = din;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      cpu_cs  = (c == cpu_cyc);
      cpu_rw  = 1'b0;
      cpu_din = cpu_d;
      @(negedge clk);
      if (c == 1) chk({nm, "_busy"}, aux_busy, 1);
      if (pio_cs && !cpu_cs) begin
        pulses++;
        pd  = pio_din;
        prw = pio_rw;
      end
      if (aux_ack) begin
        lat      = c;
        dout_ack = aux_dout;
      end
      step();
    end
    aux_req = 1'b0;
    cpu_cs  = 1'b0;
    got = sb.pop_front();
    chk({nm, "_lat"}, lat, got.lat);
    chk({nm, "_pulses"}, pulses, 1);
    chk({nm, "_pio_rw"}, prw, got.prw);
    chk({nm, "_pio_din"}, pd, got.pdin);
    chk({nm, "_dout"}, dout_ack, got.dout);
  endtask

  initial begin
    int acks;
    int pulses;
    int ackc;
    chk_cnt  = 0;
    pass_cnt = 0;
    reset    = 1'b1;
    cpu_cs   = 1'b0;
    cpu_rw   = 1'b1;
    cpu_din  = 8'h00;
    aux_req  = 1'b0;
    aux_rw   = 1'b0;
    aux_din  = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'hff};
    vecs[1] = '{1'b1, 1'b0, 8'h5a, 1'b1, 1'b0, 8'h5a, 8'hff};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h5a};
    vecs[3] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 8'hff};
    vecs[4] = '{1'b1, 1'b0, 8'ha5, 1'b1, 1'b0, 8'ha5, 8'hff};
    vecs[5] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 8'ha5};
    vecs[6] = '{1'b0, 1'b1, 8'hff, 1'b0, 1'b1, 8'h00, 8'hff};
    vecs[7] = '{1'b1, 1'b0, 8'h5a, 1'b1, 1'b0, 8'h5a, 8'hff};
    vecs[8] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h5a};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", aux_ack, 0);
    chk("rst_busy", aux_busy, 0);
    chk("rst_starved", aux_starved, 0);
    chk("rst_aux_dout", aux_dout, 8'hff);
    chk("rst_pio_cs", pio_cs, 0);
    chk("rst_pio_rw", pio_rw, 1);
    chk("rst_pio_din", pio_din, 8'h00);
    chk("rst_cpu_dout", cpu_dout, 8'hff);
    step();
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 9; i++) begin
      cpu_cs  = vecs[i].cs;
      cpu_rw  = vecs[i].rw;
      cpu_din = vecs[i].din;
      @(negedge clk);
      chk($sformatf("vec%0d_pio_cs", i), pio_cs, vecs[i].e_cs);
      chk($sformatf("vec%0d_pio_rw", i), pio_rw, vecs[i].e_rw);
      chk($sformatf("vec%0d_pio_din", i), pio_din, vecs[i].e_din);
      chk($sformatf("vec%0d_cpu_dout", i), cpu_dout, vecs[i].e_dout);
      step();
    end
    idle(3);

    aux_txn("auxwr", 1'b0, 8'hc3, -1, 8'h00, 3, 8'hff, 8'hc3);
    cpu_read_chk("rd_after_auxwr", 8'hc3);
    idle(3);

    aux_txn("conflict", 1'b1, 8'h00, 2, 8'h11, 7, 8'h11, 8'h00);
    aux_txn("worst", 1'b1, 8'h00, 0, 8'h81, 5, 8'h81, 8'h00);
    cpu_read_chk("rd_after_auxrd", 8'h81);
    idle(3);

    aux_req = 1'b1;
    aux_rw  = 1'b0;
    aux_din = 8'h99;
    cpu_cs  = 1'b1;
    cpu_rw  = 1'b1;
    step();
    aux_req = 1'b0;
    cpu_cs  = 1'b0;
    @(negedge clk);
    chk("drop_busy_wait", aux_busy, 1);
    step();
    acks   = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("drop_busy_clr", aux_busy, 0);
      if (aux_ack) acks++;
      if (pio_cs) pulses++;
      step();
    end
    chk("drop_acks", acks, 0);
    chk("drop_pulses", pulses, 0);
    cpu_read_chk("rd_after_drop", 8'h81);

    aux_req = 1'b1;
    aux_rw  = 1'b0;
    aux_din = 8'h42;
    ackc    = -1;
    for (int i = 0; i < 1200 && ackc < 0; i++) begin
      cpu_cs = (i < 1100) && (i % 2 == 0);
      cpu_rw = 1'b1;
      @(negedge clk);
      if (i == 1023) chk("starve_pre", aux_starved, 0);
      if (i == 1024) chk("starve_set", aux_starved, 1);
      if (i == 1099) chk("starve_hold", aux_starved, 1);
      if (aux_ack) ackc = i;
      step();
    end
    aux_req = 1'b0;
    cpu_cs  = 1'b0;
    chk("starve_ack_cyc", ackc, 1103);
    @(negedge clk);
    chk("starve_clr", aux_starved, 0);
    step();
    cpu_read_chk("rd_after_starve", 8'h42);
    idle(3);

    aux_req = 1'b1;
    aux_rw  = 1'b1;
    step();
    step();
    #2;
    chk("mid_issue_pio_cs", pio_cs, 1);
    chk("mid_issue_busy", aux_busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_pio_cs", pio_cs, 0);
    chk("arst_busy", aux_busy, 0);
    chk("arst_ack", aux_ack, 0);
    chk("arst_starved", aux_starved, 0);
    chk("arst_aux_dout", aux_dout, 8'hff);
    aux_req = 1'b0;
    step();
    reset = 1'b0;
    acks  = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (aux_ack || aux_busy) acks++;
      step();
    end
    chk("post_rst_quiet", acks, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
